// File: rtl/host_cmd_engine.sv
// Host-side command engine: sends a 16-bit command over a byte UART (high byte
// first), then checks an ack (SEND), polls a register until masked bits are
// set (POLL), or streams a capture dump of programmable length (DUMP).
module host_cmd_engine #(
    parameter int          LEN_W    = 16,
    parameter int          POLL_GAP = 400,
    parameter int          POLL_MAX = 200,
    parameter int          TIMEOUT  = 6000,
    parameter logic [7:0]  ACK      = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [15:0]      cmd_i,
    input  logic [7:0]       poll_mask_i,
    input  logic [LEN_W-1:0] dump_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       err_o,
    output logic [7:0]       resp_o,
    output logic             byte_vld_o,
    output logic [7:0]       byte_out_o,
    output logic [7:0]       tx_data_o,
    output logic             trmt_o,
    input  logic             tx_done_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_rdy_i,
    output logic             clr_rx_rdy_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int ATT_W = $clog2(POLL_MAX + 1);

    localparam logic [1:0] OP_POLL = 2'd1;
    localparam logic [1:0] OP_DUMP = 2'd2;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NAK  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_POLL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_TX_HI, S_W_HI, S_TX_LO, S_W_LO, S_RX_WAIT, S_GAP
    } state_t;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [15:0]        cmd_q;
    logic [7:0]         mask_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [GAP_W-1:0]   gap_q;
    logic [ATT_W-1:0]   att_q;
    logic               busy_q, done_q, byte_vld_q, trmt_q, clr_q;
    logic [1:0]         err_q;
    logic [7:0]         resp_q, byte_out_q, tx_data_q;
    logic               rx_take;

    // rx_rdy is a level that the receiver only drops after seeing our clear
    // pulse, so a byte is not taken again in the cycle the clear is visible.
    assign rx_take = rx_rdy_i && !clr_q;

    // Sequencer with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            cmd_q      <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            att_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_vld_q <= 1'b0;
            trmt_q     <= 1'b0;
            clr_q      <= 1'b0;
            err_q      <= '0;
            resp_q     <= '0;
            byte_out_q <= '0;
            tx_data_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            byte_vld_q <= 1'b0;
            trmt_q     <= 1'b0;
            clr_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q      <= op_i;
                        cmd_q     <= cmd_i;
                        mask_q    <= poll_mask_i;
                        len_q     <= dump_len_i;
                        cnt_q     <= '0;
                        att_q     <= ATT_W'(1);
                        err_q     <= ERR_OK;
                        busy_q    <= 1'b1;
                        tx_data_q <= cmd_i[15:8];
                        trmt_q    <= 1'b1;
                        state_q   <= S_TX_HI;
                    end
                end
                S_TX_HI: state_q <= S_W_HI;
                S_W_HI: begin
                    if (tx_done_i) begin
                        tx_data_q <= cmd_q[7:0];
                        trmt_q    <= 1'b1;
                        state_q   <= S_TX_LO;
                    end
                end
                S_TX_LO: state_q <= S_W_LO;
                S_W_LO: begin
                    if (tx_done_i) begin
                        if (op_q == OP_DUMP && len_q == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= ERR_OK;
                            state_q <= S_IDLE;
                        end else begin
                            tmo_q   <= '0;
                            state_q <= S_RX_WAIT;
                        end
                    end
                end
                S_RX_WAIT: begin
                    // A byte arriving in the expiry cycle still counts.
                    if (rx_take) begin
                        resp_q <= rx_data_i;
                        clr_q  <= 1'b1;
                        tmo_q  <= '0;
                        case (op_q)
                            OP_POLL: begin
                                if ((rx_data_i & mask_q) != 8'h00) begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    err_q   <= ERR_OK;
                                    state_q <= S_IDLE;
                                end else if (att_q == ATT_W'(POLL_MAX)) begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    err_q   <= ERR_POLL;
                                    state_q <= S_IDLE;
                                end else begin
                                    gap_q   <= '0;
                                    state_q <= S_GAP;
                                end
                            end
                            OP_DUMP: begin
                                byte_vld_q <= 1'b1;
                                byte_out_q <= rx_data_i;
                                cnt_q      <= cnt_q + 1'b1;
                                if (cnt_q + 1'b1 == len_q) begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    err_q   <= ERR_OK;
                                    state_q <= S_IDLE;
                                end
                            end
                            default: begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                err_q   <= (rx_data_i == ACK) ? ERR_OK : ERR_NAK;
                                state_q <= S_IDLE;
                            end
                        endcase
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= ERR_TMO;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                        att_q     <= att_q + 1'b1;
                        tx_data_q <= cmd_q[15:8];
                        trmt_q    <= 1'b1;
                        state_q   <= S_TX_HI;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign resp_o       = resp_q;
    assign byte_vld_o   = byte_vld_q;
    assign byte_out_o   = byte_out_q;
    assign tx_data_o    = tx_data_q;
    assign trmt_o       = trmt_q;
    assign clr_rx_rdy_o = clr_q;

endmodule

// File: tb/tb_host_cmd_engine.sv
// Directed bench for host_cmd_engine with small UART tx/rx behavioural models.
module tb_host_cmd_engine;

    localparam int LEN_W    = 16;
    localparam int POLL_GAP = 8;
    localparam int POLL_MAX = 4;
    localparam int TIMEOUT  = 50;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [15:0]      cmd;
    logic [7:0]       poll_mask;
    logic [LEN_W-1:0] dump_len;
    logic             busy, done, byte_vld, trmt, clr_rx_rdy;
    logic [1:0]       err;
    logic [7:0]       resp, byte_out, tx_data, rx_data;
    logic             tx_done, rx_rdy;
    logic [30:0]      outs;

    host_cmd_engine #(.LEN_W(LEN_W), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX),
                      .TIMEOUT(TIMEOUT), .ACK(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .cmd_i(cmd),
        .poll_mask_i(poll_mask), .dump_len_i(dump_len), .busy_o(busy),
        .done_o(done), .err_o(err), .resp_o(resp), .byte_vld_o(byte_vld),
        .byte_out_o(byte_out), .tx_data_o(tx_data), .trmt_o(trmt),
        .tx_done_i(tx_done), .rx_data_i(rx_data), .rx_rdy_i(rx_rdy),
        .clr_rx_rdy_o(clr_rx_rdy)
    );

    always #5 clk = ~clk;

    assign outs = {busy, done, err, resp, byte_vld, byte_out, tx_data, trmt, clr_rx_rdy};

    // Model controls (written only by the main sequence)
    logic       mdl_clr;
    logic [7:0] rx_mem [0:511];
    int         rx_len, per_pair;

    // UART transmitter model: logs bytes, answers tx_done 3 cycles after trmt
    logic [7:0] tx_log [0:15];
    int         tx_n, pairs, tx_cd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || mdl_clr) begin
            tx_n <= 0; pairs <= 0; tx_cd <= 0; tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (trmt) begin
                if (tx_n < 16) tx_log[tx_n] <= tx_data;
                tx_n  <= tx_n + 1;
                tx_cd <= 3;
                if (tx_n % 2 == 1) pairs <= pairs + 1;
            end else if (tx_cd != 0) begin
                tx_cd <= tx_cd - 1;
                if (tx_cd == 1) tx_done <= 1'b1;
            end
        end
    end

    // UART receiver model: releases per_pair bytes per command pair sent
    int rx_idx, rx_dly;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || mdl_clr) begin
            rx_rdy <= 1'b0; rx_data <= 8'h00; rx_idx <= 0; rx_dly <= 0;
        end else if (rx_rdy) begin
            if (clr_rx_rdy) rx_rdy <= 1'b0;
        end else if (rx_idx < rx_len && rx_idx < pairs * per_pair) begin
            if (rx_dly == 2) begin
                rx_rdy  <= 1'b1;
                rx_data <= rx_mem[rx_idx];
                rx_idx  <= rx_idx + 1;
                rx_dly  <= 0;
            end else begin
                rx_dly <= rx_dly + 1;
            end
        end
    end

    // Output monitor, sampled 1 time unit after each rising edge
    logic [7:0] vld_log [0:511];
    int cyc, vld_n, done_n, clr_n, done_cyc, last_vld_cyc, last_txd_cyc;
    int last_clr_cyc, min_gap;
    bit have_clr;
    initial begin
        cyc = 0; vld_n = 0; done_n = 0; clr_n = 0; done_cyc = 0;
        last_vld_cyc = 0; last_txd_cyc = 0; last_clr_cyc = 0;
        min_gap = 1000000; have_clr = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mdl_clr) begin
                vld_n = 0; done_n = 0; clr_n = 0; min_gap = 1000000; have_clr = 0;
            end else begin
                if (clr_rx_rdy) begin
                    clr_n++; last_clr_cyc = cyc; have_clr = 1;
                end
                if (trmt && have_clr) begin
                    if (cyc - last_clr_cyc < min_gap) min_gap = cyc - last_clr_cyc;
                    have_clr = 0;
                end
                if (tx_done) last_txd_cyc = cyc;
                if (byte_vld) begin
                    if (vld_n < 512) vld_log[vld_n] = byte_out;
                    vld_n++; last_vld_cyc = cyc;
                end
                if (done) begin
                    done_n++; done_cyc = cyc;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] c,
                          input logic [7:0] m, input logic [LEN_W-1:0] l);
        @(negedge clk); mdl_clr = 1'b1;
        @(negedge clk); mdl_clr = 1'b0;
        op = o; cmd = c; poll_mask = m; dump_len = l; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_n == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done_n != 0), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; cmd = '0; poll_mask = '0;
        dump_len = '0; mdl_clr = 1'b0; rx_len = 0; per_pair = 0;
        #3;
        chk("reset_outputs", 32'(outs), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // SEND 4110 with ack A5; a second start while busy must be ignored
        rx_mem[0] = 8'hA5; rx_len = 1; per_pair = 1;
        run_op(2'd0, 16'h4110, 8'h00, '0);
        chk("send_busy", 32'(busy), 32'd1);
        op = 2'd0; cmd = 16'hFFFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("send_done", 300);
        chk("send_tx_count", 32'(tx_n), 32'd2);
        chk("send_tx_hi", 32'(tx_log[0]), 32'h41);
        chk("send_tx_lo", 32'(tx_log[1]), 32'h10);
        chk("send_err", 32'(err), 32'd0);
        chk("send_resp", 32'(resp), 32'hA5);
        chk("send_busy_fall", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("send_single_done", 32'(done_n), 32'd1);

        // SEND with a NAK byte
        rx_mem[0] = 8'hEE;
        run_op(2'd0, 16'h4110, 8'h00, '0);
        wait_done("nak_done", 300);
        chk("nak_err", 32'(err), 32'd1);
        chk("nak_resp", 32'(resp), 32'hEE);

        // Reserved op behaves as SEND; start clears the previous err
        rx_mem[0] = 8'hA5;
        run_op(2'd3, 16'h1234, 8'h00, '0);
        chk("op3_err_cleared", 32'(err), 32'd0);
        wait_done("op3_done", 300);
        chk("op3_tx", {16'h0, tx_log[0], tx_log[1]}, 32'h1234);
        chk("op3_err", 32'(err), 32'd0);

        // POLL hits on the third attempt
        rx_mem[0] = 8'h00; rx_mem[1] = 8'h00; rx_mem[2] = 8'h21; rx_len = 3;
        run_op(2'd1, 16'h0000, 8'h20, '0);
        wait_done("poll_done", 1000);
        chk("poll_tx_count", 32'(tx_n), 32'd6);
        chk("poll_tx_bytes", 32'(tx_log[0] | tx_log[1] | tx_log[2] | tx_log[3] |
                                 tx_log[4] | tx_log[5]), 32'd0);
        chk("poll_err", 32'(err), 32'd0);
        chk("poll_resp", 32'(resp), 32'h21);
        chk("poll_gap_min", 32'(min_gap >= POLL_GAP), 32'd1);

        // POLL never hits: exactly POLL_MAX attempts
        for (int i = 0; i < 10; i++) rx_mem[i] = 8'h00;
        rx_len = 10;
        run_op(2'd1, 16'h0202, 8'h20, '0);
        wait_done("pollx_done", 1000);
        chk("pollx_tx_count", 32'(tx_n), 32'd8);
        chk("pollx_attempts", 32'(clr_n), 32'd4);
        chk("pollx_err", 32'(err), 32'd3);
        repeat (10) @(negedge clk);
        chk("pollx_err_hold", 32'(err), 32'd3);
        chk("pollx_tx_final", 32'(tx_n), 32'd8);

        // DUMP of 384 bytes
        for (int i = 0; i < 384; i++) rx_mem[i] = 8'(i);
        rx_len = 384; per_pair = 384;
        run_op(2'd2, 16'h8100, 8'h00, 16'd384);
        wait_done("dump_done", 6000);
        begin
            int bad = 0;
            for (int i = 0; i < 384; i++) if (vld_log[i] !== 8'(i)) bad++;
            chk("dump_order", 32'(bad), 32'd0);
        end
        chk("dump_count", 32'(vld_n), 32'd384);
        chk("dump_tx", {16'h0, tx_log[0], tx_log[1]}, 32'h8100);
        chk("dump_err", 32'(err), 32'd0);
        chk("dump_resp", 32'(resp), 32'h7F);

        // DUMP where the source stops after 100 bytes
        rx_len = 100;
        run_op(2'd2, 16'h8100, 8'h00, 16'd384);
        wait_done("dtmo_done", 6000);
        chk("dtmo_count", 32'(vld_n), 32'd100);
        chk("dtmo_err", 32'(err), 32'd2);
        chk("dtmo_latency", 32'(done_cyc - last_vld_cyc), 32'(TIMEOUT));
        chk("dtmo_resp", 32'(resp), 32'h63);

        // DUMP of zero length: done one cycle after the low byte completes
        rx_len = 0; per_pair = 0;
        run_op(2'd2, 16'h8100, 8'h00, 16'd0);
        wait_done("dzero_done", 300);
        chk("dzero_tx_count", 32'(tx_n), 32'd2);
        chk("dzero_latency", 32'(done_cyc - last_txd_cyc), 32'd1);
        chk("dzero_no_bytes", 32'(vld_n + clr_n), 32'd0);
        chk("dzero_err", 32'(err), 32'd0);

        // Reset in the middle of a DUMP
        for (int i = 0; i < 384; i++) rx_mem[i] = 8'(i);
        rx_len = 384; per_pair = 384;
        run_op(2'd2, 16'h8100, 8'h00, 16'd384);
        begin
            int k = 0;
            while (vld_n < 50 && k < 3000) begin
                @(negedge clk);
                k++;
            end
            chk("rst_mid_reached", 32'(vld_n >= 50), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'(outs), 32'd0);
        repeat (5) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_n), 32'd0);
        chk("rst_mid_outputs_held", 32'(outs), 32'd0);
        rst_n = 1'b1;
        rx_mem[0] = 8'hA5; rx_len = 1; per_pair = 1;
        run_op(2'd0, 16'h5AC3, 8'h00, '0);
        wait_done("post_rst_done", 300);
        chk("post_rst_tx", {16'h0, tx_log[0], tx_log[1]}, 32'h5AC3);
        chk("post_rst_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
